// File: rtl/rx_nibble_streamer_if.sv
// -----------------------------------------------------------------------------
// rx_nibble_streamer_if
// Sample-stream bundle between the usiq FIFO read side and rx_nibble_streamer.
//   s_tdata   [23:0] I/Q sample word
//   s_tvalid         word available
//   s_tready         word accepted when s_tvalid & s_tready (driven by sink)
//   s_tlast          last word of frame
//   s_tuser   [1:0]  frame tag
//   s_tlength [10:0] FIFO fill level
// Modports: master = FIFO side (source), slave = streamer side (sink).
// -----------------------------------------------------------------------------
interface rx_nibble_streamer_if;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [1:0]  s_tuser;
    logic [10:0] s_tlength;

    modport master (
        output s_tdata, s_tvalid, s_tlast, s_tuser, s_tlength,
        input  s_tready
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, s_tuser, s_tlength,
        output s_tready
    );
endinterface

// File: rtl/rx_nibble_streamer.sv
// -----------------------------------------------------------------------------
// rx_nibble_streamer
// Takes 24-bit I/Q words from the usiq FIFO and hands them to the Pi one
// nibble at a time, MSB first. Each transition of pi_rd_tgl requests the
// next nibble. Requests arriving with no word loaded count as underruns.
// A hysteresis flag (pi_samples) tells the Pi when a block of samples is
// waiting in the FIFO.
//
// Ports:
//   clk            clk_internal domain clock, rising edge
//   rst            asynchronous active-high reset
//   s_axis         rx_nibble_streamer_if.slave sample stream (s_tdata,
//                  s_tvalid, s_tready, s_tlast, s_tuser, s_tlength)
//   pi_rd_tgl      nibble request toggle, already synchronised to clk
//   pi_data  [3:0] current nibble to the Pi DDR mux (registered)
//   pi_samples     block-ready flag (registered)
//   underrun_cnt   saturating count of requests that found no data
//
// Optional build macro RX_NIBBLE_TAG_EN: when defined every word carries a
// 7th nibble {s_tlast, s_tuser[1:0], odd parity of s_tdata}.
// -----------------------------------------------------------------------------
module rx_nibble_streamer #(
    parameter int unsigned THRESH_HI = 256,
    parameter int unsigned THRESH_LO = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    rx_nibble_streamer_if.slave         s_axis,
    input  logic                        pi_rd_tgl,
    output logic [3:0]                  pi_data,
    output logic                        pi_samples,
    output logic [7:0]                  underrun_cnt
);

`ifdef RX_NIBBLE_TAG_EN
    localparam int          SH_W     = 28;
    localparam logic [2:0]  LAST_IDX = 3'd6;

    // Odd parity bit: makes the total number of ones (data + bit) odd.
    function automatic logic odd_parity(input logic [23:0] d);
        return ~(^d);
    endfunction
`else
    localparam int          SH_W     = 24;
    localparam logic [2:0]  LAST_IDX = 3'd5;
`endif

    localparam logic [10:0] HI_L = 11'(THRESH_HI);
    localparam logic [10:0] LO_L = 11'(THRESH_LO);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          state_r, state_nx_s;
    logic [2:0]      idx_r, idx_nx_s;
    logic [SH_W-1:0] shreg_r, shreg_nx_s;
    logic [3:0]      pi_data_r, pi_data_nx_s;
    logic            pi_samples_r, pi_samples_nx_s;
    logic [7:0]      underrun_r, underrun_nx_s;
    logic            tgl_r;
    logic            req_s;
    logic            tready_s;
    logic [SH_W-1:0] load_word_s;

    // One request per transition of the (already synchronised) toggle.
    assign req_s = pi_rd_tgl ^ tgl_r;

`ifdef RX_NIBBLE_TAG_EN
    assign load_word_s = {s_axis.s_tdata, s_axis.s_tlast, s_axis.s_tuser,
                          odd_parity(s_axis.s_tdata)};
`else
    assign load_word_s = s_axis.s_tdata;
`endif

    // Ready is forced low during reset so nothing is accepted into a
    // register that is being cleared.
    assign s_axis.s_tready = tready_s & ~rst;

    assign pi_data      = pi_data_r;
    assign pi_samples   = pi_samples_r;
    assign underrun_cnt = underrun_r;

    // Next-state / datapath decode for the nibble shifter.
    always_comb begin
        state_nx_s   = state_r;
        idx_nx_s     = idx_r;
        shreg_nx_s   = shreg_r;
        pi_data_nx_s = pi_data_r;
        tready_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tready_s = 1'b1;
                if (s_axis.s_tvalid) begin
                    state_nx_s   = ST_SHIFT;
                    idx_nx_s     = 3'd0;
                    shreg_nx_s   = load_word_s;
                    pi_data_nx_s = load_word_s[SH_W-1 -: 4];
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (req_s && (idx_r == LAST_IDX)) begin
                    // Final nibble consumed: chain the next word with no gap
                    // if one is waiting, otherwise park with a zero nibble.
                    tready_s = 1'b1;
                    if (s_axis.s_tvalid) begin
                        state_nx_s   = ST_SHIFT;
                        idx_nx_s     = 3'd0;
                        shreg_nx_s   = load_word_s;
                        pi_data_nx_s = load_word_s[SH_W-1 -: 4];
                    end else begin
                        state_nx_s   = ST_IDLE;
                        idx_nx_s     = 3'd0;
                        shreg_nx_s   = '0;
                        pi_data_nx_s = 4'h0;
                    end
                end else if (req_s) begin
                    // The register shifts left so the next nibble always
                    // sits just below the one currently on pi_data.
                    idx_nx_s     = idx_r + 3'd1;
                    shreg_nx_s   = {shreg_r[SH_W-5:0], 4'h0};
                    pi_data_nx_s = shreg_r[SH_W-5 -: 4];
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            default: begin
                state_nx_s   = ST_IDLE;
                idx_nx_s     = 3'd0;
                shreg_nx_s   = '0;
                pi_data_nx_s = 4'h0;
            end
        endcase
    end

    // Underrun counter: a request with no word in progress, including one
    // that coincides with an IDLE load, saturating at 255.
    always_comb begin
        if ((state_r == ST_IDLE) && req_s && (underrun_r != 8'hFF)) begin
            underrun_nx_s = underrun_r + 8'd1;
        end else begin
            underrun_nx_s = underrun_r;
        end
    end

    // Hysteresis on the FIFO fill level; between the thresholds the flag holds.
    always_comb begin
        if (s_axis.s_tlength > HI_L) begin
            pi_samples_nx_s = 1'b1;
        end else if (s_axis.s_tlength < LO_L) begin
            pi_samples_nx_s = 1'b0;
        end else begin
            pi_samples_nx_s = pi_samples_r;
        end
    end

    // State and output registers; reset drops any word mid-shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 3'd0;
            shreg_r      <= '0;
            pi_data_r    <= 4'h0;
            pi_samples_r <= 1'b0;
            underrun_r   <= 8'd0;
            tgl_r        <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            idx_r        <= idx_nx_s;
            shreg_r      <= shreg_nx_s;
            pi_data_r    <= pi_data_nx_s;
            pi_samples_r <= pi_samples_nx_s;
            underrun_r   <= underrun_nx_s;
            tgl_r        <= pi_rd_tgl;
        end
    end

endmodule

// File: tb/tb_rx_nibble_streamer.sv
// -----------------------------------------------------------------------------
// tb_rx_nibble_streamer
// Directed bench for rx_nibble_streamer. Expected nibbles are pushed to a
// scoreboard queue when a word is presented and popped as each request is
// issued. Honours RX_NIBBLE_TAG_EN when defined.
// -----------------------------------------------------------------------------
module tb_rx_nibble_streamer;

`ifdef RX_NIBBLE_TAG_EN
    localparam int NIB = 7;
`else
    localparam int NIB = 6;
`endif

    logic       clk;
    logic       rst;
    logic       pi_rd_tgl;
    logic [3:0] pi_data;
    logic       pi_samples;
    logic [7:0] underrun_cnt;

    int checks   = 0;
    int failures = 0;

    logic [3:0] sbq[$];

    rx_nibble_streamer_if sif ();

    rx_nibble_streamer #(
        .THRESH_HI (256),
        .THRESH_LO (128)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis       (sif),
        .pi_rd_tgl    (pi_rd_tgl),
        .pi_data      (pi_data),
        .pi_samples   (pi_samples),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected nibble sequence for the word currently on sif (MSB first).
    task automatic push_word(input logic [23:0] d);
        logic [23:0] t;
        for (int k = 0; k < 6; k++) begin
            t = d >> (20 - 4 * k);
            sbq.push_back(t[3:0]);
        end
`ifdef RX_NIBBLE_TAG_EN
        sbq.push_back({sif.s_tlast, sif.s_tuser, ~(^d)});
`endif
    endtask

    // Check the current nibble, issue one request, check ready in that cycle.
    task automatic nib_step(input string tag, input logic exp_rdy);
        logic [31:0] e;
        e = (sbq.size() > 0) ? 32'(sbq.pop_front()) : 32'hDEAD;
        chk({tag, "_data"}, 32'(pi_data), e);
        pi_rd_tgl = ~pi_rd_tgl;
        #1;
        chk({tag, "_rdy"}, 32'(sif.s_tready), 32'(exp_rdy));
    endtask

    initial begin
        rst           = 1'b1;
        pi_rd_tgl     = 1'b0;
        sif.s_tdata   = 24'h0;
        sif.s_tvalid  = 1'b0;
        sif.s_tlast   = 1'b0;
        sif.s_tuser   = 2'b00;
        sif.s_tlength = 11'd0;
        #2;
        chk("rst_pi_data", 32'(pi_data), 32'h0);
        chk("rst_samples", 32'(pi_samples), 32'h0);
        chk("rst_underrun", 32'(underrun_cnt), 32'h0);
        chk("rst_tready", 32'(sif.s_tready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single word 24'hABC123 through all nibbles.
        @(negedge clk);
        sif.s_tdata  = 24'hABC123;
        sif.s_tvalid = 1'b1;
        push_word(24'hABC123);
        #1;
        chk("w1_idle_rdy", 32'(sif.s_tready), 32'h1);
        for (int k = 0; k < NIB; k++) begin
            @(negedge clk);
            sif.s_tvalid = 1'b0;
            nib_step("w1", (k == NIB - 1));
        end
        @(negedge clk);
        chk("w1_end_data", 32'(pi_data), 32'h0);
        chk("w1_underrun", 32'(underrun_cnt), 32'h0);

        // Back-to-back words with no gap.
        @(negedge clk);
        sif.s_tdata  = 24'h123456;
        sif.s_tvalid = 1'b1;
        push_word(24'h123456);
        for (int j = 0; j < 2 * NIB; j++) begin
            @(negedge clk);
            if (j == 0) begin
                sif.s_tdata = 24'h789ABC;
                push_word(24'h789ABC);
            end
            if (j == NIB) sif.s_tvalid = 1'b0;
            nib_step("b2b", (j == NIB - 1) || (j == 2 * NIB - 1));
        end
        @(negedge clk);
        chk("b2b_end_data", 32'(pi_data), 32'h0);
        chk("b2b_underrun", 32'(underrun_cnt), 32'h0);
        chk("b2b_sb_empty", 32'(sbq.size()), 32'h0);

        // Empty FIFO, 300 requests: saturating underrun.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            pi_rd_tgl = ~pi_rd_tgl;
            if (n == 1) chk("ur_first", 32'(underrun_cnt), 32'h1);
        end
        @(negedge clk);
        chk("ur_sat", 32'(underrun_cnt), 32'hFF);
        chk("ur_pi_data", 32'(pi_data), 32'h0);

        // Fill-level hysteresis.
        sif.s_tlength = 11'd256;
        @(negedge clk);
        chk("hy_256", 32'(pi_samples), 32'h0);
        sif.s_tlength = 11'd257;
        #1;
        chk("hy_257_lat", 32'(pi_samples), 32'h0);
        @(negedge clk);
        chk("hy_257", 32'(pi_samples), 32'h1);
        sif.s_tlength = 11'd200;
        @(negedge clk);
        chk("hy_200", 32'(pi_samples), 32'h1);
        sif.s_tlength = 11'd128;
        @(negedge clk);
        chk("hy_128", 32'(pi_samples), 32'h1);
        sif.s_tlength = 11'd127;
        @(negedge clk);
        chk("hy_127", 32'(pi_samples), 32'h0);

        // Reset mid-word after three nibbles.
        sif.s_tlength = 11'd300;
        @(negedge clk);
        sif.s_tdata  = 24'hDEF987;
        sif.s_tvalid = 1'b1;
        push_word(24'hDEF987);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sif.s_tvalid = 1'b0;
            nib_step("mid", 1'b0);
        end
        @(negedge clk);
        chk("mid_nib3", 32'(pi_data), 32'h9);
        chk("mid_samples", 32'(pi_samples), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pi_data", 32'(pi_data), 32'h0);
        chk("arst_samples", 32'(pi_samples), 32'h0);
        chk("arst_underrun", 32'(underrun_cnt), 32'h0);
        chk("arst_tready", 32'(sif.s_tready), 32'h0);
        sbq.delete();
        sif.s_tlength = 11'd0;
        pi_rd_tgl     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_data", 32'(pi_data), 32'h0);
        chk("post_rst_underrun", 32'(underrun_cnt), 32'h0);

        // Load in IDLE coinciding with a request: underrun, word starts at 0.
        sif.s_tdata  = 24'h456789;
        sif.s_tvalid = 1'b1;
        push_word(24'h456789);
        pi_rd_tgl = ~pi_rd_tgl;
        #1;
        chk("coload_rdy", 32'(sif.s_tready), 32'h1);
        for (int k = 0; k < NIB; k++) begin
            @(negedge clk);
            sif.s_tvalid = 1'b0;
            if (k == 0) chk("coload_underrun", 32'(underrun_cnt), 32'h1);
            nib_step("coload", (k == NIB - 1));
        end
        @(negedge clk);
        chk("coload_end", 32'(pi_data), 32'h0);

`ifdef RX_NIBBLE_TAG_EN
        // Tag nibble: tlast=1, tuser=2'b10, parity of 24'h000001 -> 4'b1100.
        sif.s_tdata  = 24'h000001;
        sif.s_tlast  = 1'b1;
        sif.s_tuser  = 2'b10;
        sif.s_tvalid = 1'b1;
        push_word(24'h000001);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sif.s_tvalid = 1'b0;
            nib_step("tag", 1'b0);
        end
        @(negedge clk);
        chk("tag_const", 32'(pi_data), 32'hC);
        nib_step("tag7", 1'b1);
        @(negedge clk);
        chk("tag_end", 32'(pi_data), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_nibble_streamer.md
RX_NIBBLE_STREAMER -- requirements
Module: rx_nibble_streamer

Interface
REQ-001 SHALL have parameter THRESH_HI, default 256, pi_samples set level (FIFO words).
REQ-002 SHALL have parameter THRESH_LO, default 128, pi_samples clear level; THRESH_LO < THRESH_HI.
REQ-003 SHALL have port clk  in  1  single clock (clk_internal domain); one clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_tdata  in  24  I/Q sample word from usiq FIFO read side.
REQ-006 SHALL have port s_tvalid  in  1  sample word available.
REQ-007 SHALL have port s_tready  out  1  word accepted when s_tvalid & s_tready.
REQ-008 SHALL have port s_tlast  in  1  last word of frame.
REQ-009 SHALL have port s_tuser  in  2  frame tag.
REQ-010 SHALL have port s_tlength  in  11  FIFO fill level.
REQ-011 SHALL have port pi_rd_tgl  in  1  Pi nibble request, already synchronised to clk; each transition = one request.
REQ-012 SHALL have port pi_data  out  4  current nibble to the Pi DDR mux.
REQ-013 SHALL have port pi_samples  out  1  "block of samples ready" flag to the Pi.
REQ-014 SHALL have port underrun_cnt  out  8  saturating count of requests with no data.

Function
REQ-015 SHALL register pi_rd_tgl once and detect a request as (pi_rd_tgl XOR registered copy), one request per transition.
REQ-016 SHALL implement FSM states IDLE and SHIFT.
REQ-017 SHALL assert s_tready combinationally when state=IDLE, or when state=SHIFT and a request consumes the final nibble in that cycle.
REQ-018 SHALL, on s_tvalid & s_tready:
  - load s_tdata/s_tlast/s_tuser into a shift register;
  - set nibble index to 0;
  - enter or stay in SHIFT.
REQ-019 SHALL drive pi_data registered, MSB-first: nibble k = s_tdata[23-4k -: 4], k=0..5; nibble 0 is valid the cycle after load.
REQ-020 SHALL, in SHIFT, advance the nibble index by 1 on each request.
REQ-021 SHALL, when the final nibble is consumed, either:
  - load the next word in the same cycle if s_tvalid=1 (no gap); or
  - otherwise go to IDLE and drive pi_data=0.
REQ-022 SHALL, on a request in IDLE, increment underrun_cnt, saturating at 255.
REQ-023 SHALL treat a request in the same cycle as an IDLE load as an underrun; the loaded word still starts at nibble 0.
REQ-024 SHALL set pi_samples when s_tlength > THRESH_HI and clear it when s_tlength < THRESH_LO; otherwise hold.
REQ-025 SHALL compare s_tlength unsigned at 11 bits; pi_samples is registered with 1-cycle latency.
REQ-026 SHALL never accept a word while any nibble of the current word is unconsumed.

Reset
REQ-027 SHALL, while rst=1, asynchronously force:
  - state=IDLE, nibble index=0, shift register=0;
  - pi_data=0, pi_samples=0, underrun_cnt=0;
  - toggle copy=0.
REQ-028 SHALL hold s_tready=0 while rst=1.
REQ-029 SHALL drop a word that is mid-shift when reset asserts, with no further nibbles emitted.
REQ-030 SHALL not count the first toggle after reset release as an underrun if pi_rd_tgl=0.

Configuration
REQ-031 SHALL support macro RX_NIBBLE_TAG_EN, behaviour as follows:
  - Defined: each word emits a 7th nibble {s_tlast, s_tuser[1:0], odd parity over the 24 data bits}; the final nibble is index 6.
  - Undefined: 6 nibbles per word; tag and parity logic absent.

Verification
REQ-032 SHALL verify: load 24'hABC123, 6 toggles -> pi_data A,B,C,1,2,3, then 0; s_tready pulses once after the 6th.
REQ-033 SHALL verify: two words valid back-to-back, 12 toggles -> 12 nibbles, no IDLE cycle, no underrun.
REQ-034 SHALL verify: empty FIFO, 300 toggles -> underrun_cnt=255, pi_data=0.
REQ-035 SHALL verify: s_tlength ramp 0→257→200→127 -> pi_samples 0→1 (at 257)→1→0 (at 127).
REQ-036 SHALL verify: rst pulse after 3 nibbles -> all outputs 0 asynchronously, next word restarts at nibble 0.
REQ-037 SHALL verify, with RX_NIBBLE_TAG_EN: word 24'h000001, tlast=1, tuser=2'b10 -> 7th nibble 4'b1100.
